schoolbook_sched: RTL and testbench

- Shares one iterative shift-add (schoolbook) multiplier engine between two requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Response carries the requester ID.
- Sits between key-exchange/signature front-ends and the large-integer multiplier, giving the engine an explicit start/done sequence.

---
 rtl/schoolbook_sched_pkg.sv | 13 +
 rtl/schoolbook_core.sv | 70 +++++++
 rtl/schoolbook_sched.sv | 109 ++++++++++
 tb/tb_schoolbook_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/schoolbook_sched_pkg.sv
// Shared types for the schoolbook multiplier scheduler: FSM encoding and requester IDs.
package schoolbook_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/schoolbook_core.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first, fixed WIDTH-cycle latency.
module schoolbook_core #(
  parameter int unsigned WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   c
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             run_q, run_d;
  logic             last_bit;

  // a is kept pre-shifted by count, so each step adds a_q instead of a barrel-shifted copy
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    count_d  = count_q;
    run_d    = run_q;
    last_bit = (count_q == CW'(WIDTH - 1));
    if (start) begin
      a_d     = PW'(a);
      b_d     = b;
      acc_d   = '0;
      count_d = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      if (b_q[0]) begin
        acc_d = acc_q + a_q;
      end
      a_d     = a_q << 1;
      b_d     = b_q >> 1;
      count_d = count_q + CW'(1);
      if (last_bit) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

  assign done_c = run_q & last_bit;
  assign c      = acc_q;

endmodule

// File: rtl/schoolbook_sched.sv
// Round-robin front end that shares one schoolbook multiplier core between two requesters.
module schoolbook_sched
  import schoolbook_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_c,
  output logic                 busy
);

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             idle, grant0, grant1, start;
  logic             core_done_c;
  logic [WIDTH-1:0] op_a, op_b;

  // Contested cycles go to whichever requester was not served last
  always_comb begin
    idle   = (state_q == ST_IDLE);
    grant0 = idle & req0_valid & (~req1_valid | (rr_last_q == ID_REQ1));
    grant1 = idle & req1_valid & (~req0_valid | (rr_last_q == ID_REQ0));
    start  = grant0 | grant1;
    op_a   = grant1 ? req1_a : req0_a;
    op_b   = grant1 ? req1_b : req0_b;
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    rsp_id_d  = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0) begin
          rsp_id_d  = ID_REQ0;
          rr_last_d = ID_REQ0;
          state_d   = ST_RUN;
        end else if (grant1) begin
          rsp_id_d  = ID_REQ1;
          rr_last_d = ID_REQ1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_done_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rsp_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= ID_REQ1;
      rsp_id_q    <= ID_REQ0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  schoolbook_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (op_a),
    .b      (op_b),
    .done_c (core_done_c),
    .c      (rsp_c)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_schoolbook_sched.sv
// Bench for schoolbook_sched: directed and random traffic on an 8-bit instance, wide checks on a 256-bit one.
module tb_schoolbook_sched;

  localparam int unsigned W8 = 8;
  localparam int unsigned WW = 256;

  typedef struct packed {
    logic        id;
    logic [15:0] prod;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance signals
  logic          v0 = 0, v1 = 0, rr8 = 0;
  logic [7:0]    a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic          r0, r1, rv8, id8, busy8;
  logic [15:0]   c8;

  // 256-bit instance signals
  logic          w_v0 = 0, w_v1 = 0, w_rr = 1;
  logic [WW-1:0] w_a0 = 0, w_b0 = 0, w_a1 = 0, w_b1 = 0;
  logic          w_r0, w_r1, w_rv, w_id, w_busy;
  logic [2*WW-1:0] w_c;

  schoolbook_sched #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
    .rsp_valid(rv8), .rsp_ready(rr8), .rsp_id(id8), .rsp_c(c8), .busy(busy8)
  );

  schoolbook_sched #(.WIDTH(WW)) dut256 (
    .clk(clk), .rst(rst),
    .req0_valid(w_v0), .req0_ready(w_r0), .req0_a(w_a0), .req0_b(w_b0),
    .req1_valid(w_v1), .req1_ready(w_r1), .req1_a(w_a1), .req1_b(w_b1),
    .rsp_valid(w_rv), .rsp_ready(w_rr), .rsp_id(w_id), .rsp_c(w_c), .busy(w_busy)
  );

  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state: at most one job in flight, expected results in order
  bit   m_busy = 0;
  bit   m_last = 1;
  int   m_hs_cyc = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  bit   dut_g[$];
  int   n_done = 0;
  int   n_rsp_dut = 0;
  bit   hs0 = 0, hs1 = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // Called right after a negedge with inputs already driven; returns at the next negedge
  task automatic tick8();
    bit w0, w1, rv;
    #1;
    w0 = 1'b0;
    w1 = 1'b0;
    if (!m_busy) begin
      if (v0 && v1) begin
        w0 = m_last;
        w1 = !m_last;
      end else begin
        w0 = v0;
        w1 = v1;
      end
    end
    rv = m_busy && (cyc >= m_hs_cyc + int'(W8) + 1);
    chk("req0_ready", 512'(r0), 512'(w0));
    chk("req1_ready", 512'(r1), 512'(w1));
    chk("rsp_valid", 512'(rv8), 512'(rv));
    chk("busy", 512'(busy8), 512'(m_busy));
    if (rv) begin
      chk("rsp_id", 512'(id8), 512'(exp_q[0].id));
      chk("rsp_c", 512'(c8), 512'(exp_q[0].prod));
    end
    if (r0) dut_g.push_back(1'b0);
    if (r1) dut_g.push_back(1'b1);
    if (rv8 && rr8) n_rsp_dut++;
    if (rv && rr8) begin
      void'(exp_q.pop_front());
      m_busy = 0;
      n_done++;
    end
    if (w0 || w1) begin
      exp_q.push_back('{w1, w1 ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0)});
      m_busy   = 1;
      m_hs_cyc = cyc;
      m_last   = w1;
    end
    hs0 = w0;
    hs1 = w1;
    cyc++;
    @(negedge clk);
  endtask

  // Run until the engine is idle and no requester is waiting; accepted requesters drop valid
  task automatic drain();
    for (int i = 0; i < 400 && (m_busy || v0 || v1); i++) begin
      tick8();
      if (hs0) v0 = 0;
      if (hs1) v1 = 0;
    end
    if (m_busy || v0 || v1) chk("drain_timeout", 512'(m_busy), 512'(0));
  endtask

  task automatic run256(input string tag, input logic [WW-1:0] a, input logic [WW-1:0] b,
                        input logic [2*WW-1:0] exp);
    bit found;
    w_v0 = 1; w_a0 = a; w_b0 = b;
    #1;
    chk({tag, "_ready"}, 512'(w_r0), 512'(1));
    @(negedge clk);
    w_v0 = 0; w_a0 = '1; w_b0 = '1;
    found = 0;
    for (int i = 1; i < 400 && !found; i++) begin
      #1;
      if (w_rv) begin
        found = 1;
        chk({tag, "_latency"}, 512'(i), 512'(WW + 1));
        chk({tag, "_c"}, w_c, exp);
        chk({tag, "_id"}, 512'(w_id), 512'(0));
      end
      @(negedge clk);
    end
    if (!found) chk({tag, "_timeout"}, 512'(0), 512'(1));
    #1;
    chk({tag, "_idle_after"}, 512'(w_busy), 512'(0));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0]   ra, rb;
    logic [2*WW-1:0] ones_sq;
    int              base;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 512'(rv8), 512'(0));
    chk("rst_rsp_id", 512'(id8), 512'(0));
    chk("rst_rsp_c", 512'(c8), 512'(0));
    chk("rst_busy", 512'(busy8), 512'(0));
    chk("rst_w_busy", 512'(w_busy), 512'(0));
    @(negedge clk);
    rst = 1;

    // Both requesters valid out of reset: grants must alternate starting with req0
    dut_g.delete();
    v0 = 1; a0 = 8'd3;   b0 = 8'd5;
    v1 = 1; a1 = 8'd200; b1 = 8'd7;
    rr8 = 1;
    for (int i = 0; i < 100 && dut_g.size() < 3; i++) tick8();
    chk("t2_grant_count", 512'(dut_g.size()), 512'(3));
    if (dut_g.size() >= 3) begin
      chk("t2_grant0", 512'(dut_g[0]), 512'(0));
      chk("t2_grant1", 512'(dut_g[1]), 512'(1));
      chk("t2_grant2", 512'(dut_g[2]), 512'(0));
    end
    v0 = 0; v1 = 0;
    drain();

    // Lone requester, all-ones operands
    v0 = 1; a0 = 8'hFF; b0 = 8'hFF; rr8 = 1;
    drain();

    // Backpressure: response held for 20 cycles while req0 waits
    v1 = 1; a1 = 8'h12; b1 = 8'h34; rr8 = 0;
    tick8();
    v1 = 0; a1 = 8'h00; b1 = 8'h00;
    v0 = 1; a0 = 8'd7; b0 = 8'd9;
    repeat (W8 + 20) tick8();
    chk("t3_held_c", 512'(c8), 512'(16'h03A8));
    rr8 = 1;
    drain();

    // Asynchronous reset in the middle of a run
    v1 = 1; a1 = 8'hB7; b1 = 8'h5F; rr8 = 1;
    tick8();
    v1 = 0; a1 = 8'h00;
    repeat (4) tick8();
    rst = 0;
    #2;
    chk("mid_rst_rsp_valid", 512'(rv8), 512'(0));
    chk("mid_rst_rsp_id", 512'(id8), 512'(0));
    chk("mid_rst_rsp_c", 512'(c8), 512'(0));
    chk("mid_rst_busy", 512'(busy8), 512'(0));
    chk("mid_rst_ready1", 512'(r1), 512'(0));
    m_busy = 0;
    m_last = 1;
    exp_q.delete();
    @(negedge clk);
    rst = 1;
    v0 = 1; a0 = 8'hC3; b0 = 8'h0E;
    drain();

    // Wide instance: extreme and zero operands plus one random pair
    ones_sq = '0 - ((2*WW)'(1) << (WW + 1)) + (2*WW)'(1);
    run256("w_ones", '1, '1, ones_sq);
    rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run256("w_zero", '0, rb, '0);
    ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run256("w_rand", ra, rb, (2*WW)'(ra) * (2*WW)'(rb));

    // Random back-to-back traffic with random consumer backpressure
    base = n_done;
    hs0 = 0; hs1 = 0;
    for (int k = 0; k < 40000 && (n_done - base) < 1000; k++) begin
      if (hs0) begin
        v0 = ($urandom_range(0, 1) == 1); a0 = rnd8(); b0 = rnd8();
      end else if (!v0 && $urandom_range(0, 2) == 0) begin
        v0 = 1; a0 = rnd8(); b0 = rnd8();
      end
      if (hs1) begin
        v1 = ($urandom_range(0, 1) == 1); a1 = rnd8(); b1 = rnd8();
      end else if (!v1 && $urandom_range(0, 2) == 0) begin
        v1 = 1; a1 = rnd8(); b1 = rnd8();
      end
      rr8 = ($urandom_range(0, 3) != 0);
      tick8();
    end
    chk("rand_jobs_done", 512'((n_done - base) >= 1000), 512'(1));
    v0 = 0; v1 = 0; rr8 = 1;
    drain();
    chk("no_lost_jobs", 512'(exp_q.size()), 512'(0));
    chk("rsp_count", 512'(n_rsp_dut), 512'(n_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
